// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : Instruction fetch stage: issues PCs to instruction memory and
//            queues returned instructions with their PC for decode.
// Revision : 1.0  initial release
// ============================================================================
module fetch_stage #(
    parameter int OPD_WIDTH  = 32,
    parameter int PC_WIDTH   = 12,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PC_WIDTH-1:0]  pc_in,
    input  logic                 pc_valid,
    output logic                 pc_ready,
    input  logic                 flush,
    output logic                 imem_req,
    output logic [PC_WIDTH-1:0]  imem_addr,
    input  logic                 imem_gnt,
    input  logic                 imem_rvalid,
    input  logic [OPD_WIDTH-1:0] imem_rdata,
    output logic                 instr_valid,
    output logic [OPD_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]  instr_pc,
    input  logic                 instr_ready,
    output logic                 protocol_err
);

    localparam int c_addr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w  = c_addr_w + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  req_q, req_d;
    logic [PC_WIDTH-1:0]   addr_q, addr_d;
    logic [OPD_WIDTH-1:0]  q_data_q [FIFO_DEPTH];
    logic [OPD_WIDTH-1:0]  q_data_d [FIFO_DEPTH];
    logic [PC_WIDTH-1:0]   q_pc_q   [FIFO_DEPTH];
    logic [PC_WIDTH-1:0]   q_pc_d   [FIFO_DEPTH];
    logic [PC_WIDTH-1:0]   t_pc_q   [FIFO_DEPTH];
    logic [PC_WIDTH-1:0]   t_pc_d   [FIFO_DEPTH];
    logic [c_addr_w-1:0]   q_rd_q, q_rd_d, q_wr_q, q_wr_d;
    logic [c_addr_w-1:0]   t_rd_q, t_rd_d, t_wr_q, t_wr_d;
    logic [c_cnt_w-1:0]    q_cnt_q, q_cnt_d;
    logic [c_cnt_w-1:0]    outst_q, outst_d;
    logic [c_cnt_w-1:0]    discard_q, discard_d;
    logic                  perr_q, perr_d;

    logic                  w_gnt, w_rv_ok, w_stray, w_resp, w_drop;
    logic                  w_accept, w_pop;
    logic [c_cnt_w:0]      w_used, w_remain;

    // A response is legitimate only if some fetch (live or doomed) is owed.
    assign w_gnt    = (state_q == S_REQ) && imem_gnt;
    assign w_rv_ok  = imem_rvalid && ((outst_q != '0) || (discard_q != '0));
    assign w_stray  = imem_rvalid && !w_rv_ok;
    assign w_resp   = w_rv_ok && (discard_q == '0);
    assign w_drop   = w_rv_ok && (discard_q != '0);
    assign w_used   = {1'b0, q_cnt_q} + {1'b0, outst_q} + (c_cnt_w+1)'(req_q);
    assign w_remain = {1'b0, outst_q} + {1'b0, discard_q}
                    + (c_cnt_w+1)'(w_gnt) - (c_cnt_w+1)'(w_rv_ok);

    assign pc_ready = !rst && (state_q == S_IDLE) && !flush
                    && (w_used < (c_cnt_w+1)'(FIFO_DEPTH));
    assign w_accept = pc_valid && pc_ready;
    assign w_pop    = (q_cnt_q != '0) && instr_ready;

    assign imem_req     = req_q;
    assign imem_addr    = addr_q;
    assign instr_valid  = (q_cnt_q != '0);
    assign instr        = q_data_q[q_rd_q];
    assign instr_pc     = q_pc_q[q_rd_q];
    assign protocol_err = perr_q;

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        addr_d    = addr_q;
        q_data_d  = q_data_q;
        q_pc_d    = q_pc_q;
        t_pc_d    = t_pc_q;
        q_rd_d    = q_rd_q;
        q_wr_d    = q_wr_q;
        q_cnt_d   = q_cnt_q;
        t_rd_d    = t_rd_q;
        t_wr_d    = t_wr_q;
        outst_d   = outst_q;
        discard_d = discard_q;
        perr_d    = perr_q | w_stray;

        if (flush) begin
            // Everything owed by memory becomes a response to throw away.
            q_rd_d    = '0;
            q_wr_d    = '0;
            q_cnt_d   = '0;
            t_rd_d    = '0;
            t_wr_d    = '0;
            outst_d   = '0;
            req_d     = 1'b0;
            discard_d = w_remain[c_cnt_w-1:0];
            state_d   = (w_remain != '0) ? S_DRAIN : S_IDLE;
        end else begin
            if (w_pop) begin
                q_rd_d = q_rd_q + c_addr_w'(1);
            end
            if (w_resp) begin
                q_data_d[q_wr_q] = imem_rdata;
                q_pc_d[q_wr_q]   = t_pc_q[t_rd_q];
                q_wr_d           = q_wr_q + c_addr_w'(1);
                t_rd_d           = t_rd_q + c_addr_w'(1);
            end
            if (w_drop) begin
                discard_d = discard_q - c_cnt_w'(1);
            end
            q_cnt_d = q_cnt_q + c_cnt_w'(w_resp) - c_cnt_w'(w_pop);
            outst_d = outst_q + c_cnt_w'(w_gnt) - c_cnt_w'(w_resp);

            unique case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        req_d          = 1'b1;
                        addr_d         = pc_in;
                        t_pc_d[t_wr_q] = pc_in;
                        t_wr_d         = t_wr_q + c_addr_w'(1);
                        state_d        = S_REQ;
                    end
                end
                S_REQ: begin
                    if (imem_gnt) begin
                        req_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (discard_d == '0) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            req_q     <= 1'b0;
            addr_q    <= '0;
            q_data_q  <= '{default: '0};
            q_pc_q    <= '{default: '0};
            t_pc_q    <= '{default: '0};
            q_rd_q    <= '0;
            q_wr_q    <= '0;
            q_cnt_q   <= '0;
            t_rd_q    <= '0;
            t_wr_q    <= '0;
            outst_q   <= '0;
            discard_q <= '0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            q_data_q  <= q_data_d;
            q_pc_q    <= q_pc_d;
            t_pc_q    <= t_pc_d;
            q_rd_q    <= q_rd_d;
            q_wr_q    <= q_wr_d;
            q_cnt_q   <= q_cnt_d;
            t_rd_q    <= t_rd_d;
            t_wr_q    <= t_wr_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
            perr_q    <= perr_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Randomized self-checking bench for fetch_stage with a
//            transaction-level model of decode, memory and flush.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

    localparam int OPD_WIDTH  = 32;
    localparam int PC_WIDTH   = 12;
    localparam int FIFO_DEPTH = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [PC_WIDTH-1:0]  pc_in;
    logic                 pc_valid;
    logic                 pc_ready;
    logic                 flush;
    logic                 imem_req;
    logic [PC_WIDTH-1:0]  imem_addr;
    logic                 imem_gnt;
    logic                 imem_rvalid;
    logic [OPD_WIDTH-1:0] imem_rdata;
    logic                 instr_valid;
    logic [OPD_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]  instr_pc;
    logic                 instr_ready;
    logic                 protocol_err;

    always #5 clk = ~clk;

    fetch_stage #(
        .OPD_WIDTH (OPD_WIDTH),
        .PC_WIDTH  (PC_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_in       (pc_in),
        .pc_valid    (pc_valid),
        .pc_ready    (pc_ready),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .protocol_err(protocol_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: PCs accepted but not yet consumed, addresses owed by memory,
    // and how many owed responses belong to flushed (wrong) paths.
    logic [PC_WIDTH-1:0] exp_q[$];
    logic [PC_WIDTH-1:0] mem_q[$];
    int                  owed = 0;
    int                  cyc = 0;
    int                  p_valid = 0, p_ready = 0, p_gnt = 0, p_rv = 0, p_flush = 0;
    bit                  rand_pc = 1'b0;
    bit                  force_stray = 1'b0;
    bit                  last_acc = 1'b0;
    logic [PC_WIDTH-1:0] next_pc = '0;
    int                  first_acc = -1, first_vld = -1;
    bit                  prev_stall = 1'b0;
    logic [PC_WIDTH-1:0] prev_addr = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [OPD_WIDTH-1:0] mem_data(input logic [PC_WIDTH-1:0] a);
        return 32'hC0DE_0000 ^ (OPD_WIDTH'(a) * 32'h9E37_79B1);
    endfunction

    task automatic cycle();
        bit acc, pop, gnt_s, rv_s;
        @(negedge clk);
        cyc++;
        flush       = ($urandom_range(0, 99) < p_flush);
        pc_valid    = ($urandom_range(0, 99) < p_valid);
        pc_in       = rand_pc ? PC_WIDTH'($urandom_range(0, 1023) * 4) : next_pc;
        instr_ready = ($urandom_range(0, 99) < p_ready);
        imem_gnt    = imem_req && ($urandom_range(0, 99) < p_gnt);
        imem_rvalid = force_stray || ((mem_q.size() > 0) && ($urandom_range(0, 99) < p_rv));
        imem_rdata  = (mem_q.size() > 0 && !force_stray) ? mem_data(mem_q[0]) : OPD_WIDTH'($urandom);
        #1;
        acc   = pc_valid && pc_ready;
        pop   = instr_valid && instr_ready;
        gnt_s = imem_req && imem_gnt;
        rv_s  = imem_rvalid && !force_stray;

        if (prev_stall) begin
            check_eq("req_held", imem_req, 1);
            check_eq("addr_held", imem_addr, prev_addr);
        end
        if (flush)                     check_eq("no_accept_on_flush", pc_ready, 0);
        if (exp_q.size() >= FIFO_DEPTH) check_eq("credit_block", pc_ready, 0);
        if (owed > 0)                  check_eq("drain_block", pc_ready, 0);
        if (instr_valid && first_vld < 0) first_vld = cyc;
        if (pop) begin
            if (exp_q.size() == 0) begin
                check_eq("wrong_path_instr", instr_valid, 0);
            end else begin
                check_eq("instr_pc", instr_pc, exp_q[0]);
                check_eq("instr", instr, mem_data(exp_q[0]));
                void'(exp_q.pop_front());
            end
        end
        if (flush) exp_q.delete();
        last_acc = acc;
        if (acc) begin
            exp_q.push_back(pc_in);
            if (first_acc < 0) first_acc = cyc;
            next_pc = next_pc + PC_WIDTH'(4);
        end
        if (gnt_s) mem_q.push_back(imem_addr);
        if (rv_s) begin
            void'(mem_q.pop_front());
            if (owed > 0) owed--;
        end
        if (flush) owed = mem_q.size();
        prev_stall = imem_req && !imem_gnt && !flush;
        prev_addr  = imem_addr;
    endtask

    task automatic wait_accept();
        int k = 0;
        do begin
            cycle();
            k++;
        end while (!last_acc && k < 50);
        if (!last_acc) check_eq("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        int k = 0;
        p_valid = 0; p_flush = 0; p_ready = 100; p_gnt = 100; p_rv = 100;
        while ((exp_q.size() > 0 || mem_q.size() > 0 || instr_valid || imem_req) && k < 100) begin
            cycle();
            k++;
        end
        check_eq("drain_done", (exp_q.size() == 0 && mem_q.size() == 0 && !instr_valid), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; pc_valid = 1'b1; flush = 1'b0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; instr_ready = 1'b0; pc_in = '0; imem_rdata = '0;
        #1;
        check_eq("pc_ready_in_rst", pc_ready, 0);
        @(negedge clk);
        check_eq("rst_imem_req", imem_req, 0);
        check_eq("rst_imem_addr", imem_addr, 0);
        check_eq("rst_instr_valid", instr_valid, 0);
        check_eq("rst_instr", instr, 0);
        check_eq("rst_instr_pc", instr_pc, 0);
        check_eq("rst_protocol_err", protocol_err, 0);
        rst = 1'b0; pc_valid = 1'b0;
        exp_q.delete(); mem_q.delete();
        owed = 0; prev_stall = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Zero-wait stream of three sequential fetches, latency from accept.
        rand_pc = 1'b0; next_pc = 12'h000; first_acc = -1; first_vld = -1;
        p_valid = 100; p_ready = 100; p_gnt = 100; p_rv = 100; p_flush = 0;
        repeat (3) wait_accept();
        drain();
        check_eq("latency_accept_to_valid", first_vld - first_acc, 3);

        // Backpressure: decode stalled, queue must saturate at FIFO_DEPTH.
        next_pc = 12'h040;
        p_valid = 100; p_ready = 0; p_gnt = 100; p_rv = 100;
        repeat (12) cycle();
        check_eq("bp_model_full", exp_q.size(), FIFO_DEPTH);
        check_eq("bp_pc_ready", pc_ready, 0);
        check_eq("bp_imem_req", imem_req, 0);
        check_eq("bp_head_pc", instr_pc, 12'h040);
        drain();

        // Grant stall on 0x010 for four cycles.
        next_pc = 12'h010; p_valid = 100; p_gnt = 0; p_ready = 100;
        wait_accept();
        p_valid = 0;
        repeat (4) begin
            cycle();
            check_eq("stall_req", imem_req, 1);
            check_eq("stall_addr", imem_addr, 12'h010);
            check_eq("stall_pc_ready", pc_ready, 0);
        end
        drain();

        // Two grants in flight, then flush; next fetch 0x100 must deliver.
        next_pc = 12'h200; p_valid = 100; p_gnt = 100; p_rv = 0; p_ready = 100;
        repeat (2) wait_accept();
        p_valid = 0;
        for (int k = 0; k < 10 && mem_q.size() < 2; k++) cycle();
        check_eq("two_in_flight", mem_q.size(), 2);
        p_flush = 100; p_valid = 100; next_pc = 12'h0F0;
        cycle();
        check_eq("flush_owed", owed, 2);
        p_flush = 0; next_pc = 12'h100; p_rv = 100;
        wait_accept();
        check_eq("post_flush_pc", exp_q[0], 12'h100);
        drain();

        // Randomized traffic with occasional flushes.
        rand_pc = 1'b1;
        p_valid = 70; p_ready = 60; p_gnt = 60; p_rv = 50; p_flush = 4;
        repeat (3000) cycle();
        drain();
        check_eq("no_protocol_err", protocol_err, 0);

        // Stray response with nothing outstanding.
        force_stray = 1'b1; p_valid = 0;
        cycle();
        force_stray = 1'b0;
        cycle();
        check_eq("stray_perr", protocol_err, 1);
        check_eq("stray_queue", instr_valid, 0);
        repeat (3) cycle();
        check_eq("stray_sticky", protocol_err, 1);
        do_reset();
        check_eq("perr_cleared", protocol_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
